// File: rtl/modport_counter_pkg.sv
// rtl/modport_counter_pkg.sv - shared constants and types for the modport_counter block
package modport_counter_pkg;

  // Counter width used by the default configuration.
  localparam int COUNTER_WIDTH = 4;

  // Value the counter takes while reset is asserted.
  localparam logic [COUNTER_WIDTH-1:0] COUNTER_RST_VAL = 4'h0;

  // Counter value type for the default configuration.
  typedef logic [COUNTER_WIDTH-1:0] count_t;

endpackage

// File: rtl/modport_counter.sv
// rtl/modport_counter.sv - free-running up counter with parallel load and async reset
module modport_counter
  import modport_counter_pkg::*;
#(
  parameter int               WIDTH   = COUNTER_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(COUNTER_RST_VAL)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  // Next-value selection: load wins over increment; the incrementer wraps naturally.
  always_comb begin
    w_next = r_count + ONE;
    if (load) begin
      w_next = data_in;
    end
  end

  // Counter register; reset clears it immediately, independent of the clock.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_count <= RST_VAL;
    end else begin
      r_count <= w_next;
    end
  end

  // The output comes straight from the register, so nothing combinational reaches it.
  assign data_out = r_count;

`ifndef SYNTHESIS
  logic             r_chk_valid;
  logic             r_chk_load;
  logic [WIDTH-1:0] r_chk_prev;
  logic [WIDTH-1:0] r_chk_data;

  // Remember what the previous edge saw so the following edge can judge the update.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_chk_valid <= 1'b0;
      r_chk_load  <= 1'b0;
      r_chk_prev  <= RST_VAL;
      r_chk_data  <= '0;
    end else begin
      r_chk_valid <= 1'b1;
      r_chk_load  <= load;
      r_chk_prev  <= r_count;
      r_chk_data  <= data_in;
    end
  end

  // Behavioural checks on reset value, known inputs/outputs, load and increment.
  always @(posedge clock) begin
    if (rst) begin
      a_rst: assert (r_count == RST_VAL);
    end else begin
      a_load_known: assert (!$isunknown(load));
      a_count_known: assert (!$isunknown(r_count));
      if (r_chk_valid && r_chk_load) begin
        a_load: assert (r_count == r_chk_data);
      end
      if (r_chk_valid && !r_chk_load) begin
        a_incr: assert (r_count == r_chk_prev + ONE);
      end
    end
  end
`endif

endmodule

// File: tb/tb_modport_counter.sv
// tb/tb_modport_counter.sv - randomized and directed self-checking bench for modport_counter
module tb_modport_counter;

  logic       clock;
  logic       rst;
  logic       load;
  logic [3:0] data_in;
  logic [3:0] data_out;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    model   = 0;
  string last_tag = "reset";

  logic [15:0] loaded_mask = '0;
  int          wrap_seen   = 0;
  int          rst_on_load = 0;

  modport_counter #(.WIDTH(4), .RST_VAL(4'h0)) dut (
    .clock    (clock),
    .rst      (rst),
    .load     (load),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called 1 unit after an edge. Checks the result of the previous edge 1 unit before
  // the next one, then lets that edge capture the inputs given here.
  task automatic step(input logic r, input logic l, input logic [3:0] d, input string tag);
    rst     = r;
    load    = l;
    data_in = d;
    if (r) model = 0;
    #8;
    check(last_tag, {28'd0, data_out}, model);
    @(posedge clock);
    if (r) begin
      if (l) rst_on_load++;
      model = 0;
    end else if (l) begin
      loaded_mask[d] = 1'b1;
      model = d;
    end else begin
      if (model == 15) wrap_seen++;
      model = (model + 1) % 16;
    end
    last_tag = tag;
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    load    = 1'b0;
    data_in = 4'h0;
    @(posedge clock);
    #1;
    check("reset_val", {28'd0, data_out}, 0);

    // Free-run through the wrap point.
    for (int i = 0; i < 18; i++) step(1'b0, 1'b0, 4'h0, "free_run");

    // Count to 7, then assert reset between edges.
    step(1'b1, 1'b0, 4'h0, "rst_a");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 4'h0, "count7");
    #3;
    check("pre_rst", {28'd0, data_out}, 7);
    rst = 1'b1;
    #1;
    check("async_rst", {28'd0, data_out}, 0);
    model = 0;
    @(posedge clock);
    #1;
    last_tag = "rst_hold";
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, "after_rel");

    // Single load followed by counting up to the wrap.
    step(1'b0, 1'b1, 4'hA, "load_a");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'h0, "load_cnt");

    // Back-to-back loads.
    step(1'b0, 1'b1, 4'h3, "b2b_3");
    step(1'b0, 1'b1, 4'h9, "b2b_9");
    step(1'b0, 1'b1, 4'hF, "b2b_f");
    step(1'b0, 1'b0, 4'h0, "b2b_wrap");

    // Reset and load on the same edge.
    step(1'b1, 1'b1, 4'h5, "collide");
    step(1'b0, 1'b0, 4'h0, "collide_rel");

    // Random regression.
    for (int i = 0; i < 1000; i++) begin
      int          pick_r;
      int          pick_l;
      logic [3:0]  d;
      pick_r = $urandom_range(99);
      pick_l = $urandom_range(99);
      d      = 4'($urandom_range(15));
      step(pick_r < 5, pick_l < 30, d, "random");
    end

    #8;
    check(last_tag, {28'd0, data_out}, model);

    check("cov_all_loaded", {16'd0, loaded_mask}, 32'h0000_FFFF);
    check("cov_wrap", {31'd0, wrap_seen > 0}, 1);
    check("cov_rst_on_load", {31'd0, rst_on_load > 0}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
